// File: rtl/t01_clkdiv_pkg.sv
// Shared defaults and types for the multi-channel clock divider.
// Imported by the channel slice, the top level and the bench.
package t01_clkdiv_pkg;

   localparam int CLKDIV_CNT_W       = 11;
   localparam int CLKDIV_DEFAULT_DIV = 1250;

   typedef logic [CLKDIV_CNT_W-1:0] div_t;

   // Channel-select width, never narrower than one bit.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/t01_clkdiv_chan.sv
// One divider channel: counter, divisor register, toggle and tick.
// Half period is div+1 cycles; the wrap always uses the divisor held before a write.
module t01_clkdiv_chan
   import t01_clkdiv_pkg::*;
#(
   parameter int CNT_W       = CLKDIV_CNT_W,
   parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_div,
   output logic             o_clk,
   output logic             o_tick
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic             r_clk;
   logic             r_tick;
   logic             w_wrap;

   // ">=" rather than "==" so a divisor shrunk below cnt wraps at once.
   assign w_wrap = (r_cnt >= r_div);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= DIV_RST;
      end else if (i_wr) begin
         r_div <= i_div;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_clk  <= 1'b0;
         r_tick <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= '0;
         r_clk  <= 1'b0;
         r_tick <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else if (!w_wrap) begin
         r_cnt  <= r_cnt + 1'b1;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= '0;
         r_clk  <= ~r_clk;
         r_tick <= 1'b1;
      end
   end

   assign o_clk  = r_clk;
   assign o_tick = r_tick;

endmodule

// File: rtl/t01_clkdiv_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Holds the divisor write decode, the channel range check and wr_err_o.
module t01_clkdiv_multi
   import t01_clkdiv_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int CNT_W       = CLKDIV_CNT_W,
   parameter  int DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
   localparam int CH_W        = ch_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en_i,
   input  logic              sync_clr_i,
   input  logic              wr_en_i,
   input  logic [CH_W-1:0]   wr_ch_i,
   input  logic [CNT_W-1:0]  wr_div_i,
   output logic [NUM_CH-1:0] clk_o,
   output logic [NUM_CH-1:0] tick_o,
   output logic              wr_err_o
);

   logic              w_in_rng;
   logic              w_wr_ok;
   logic [NUM_CH-1:0] w_wr_sel;
   logic              r_wr_err;

   assign w_in_rng = (32'(wr_ch_i) < 32'(NUM_CH));
   assign w_wr_ok  = wr_en_i && w_in_rng;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_err <= 1'b0;
      end else begin
         r_wr_err <= wr_en_i && !w_in_rng;
      end
   end

   assign wr_err_o = r_wr_err;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_wr_sel[c] = w_wr_ok && (wr_ch_i == CH_W'(c));

      t01_clkdiv_chan #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .i_en   (en_i[c]),
         .i_clr  (sync_clr_i),
         .i_wr   (w_wr_sel[c]),
         .i_div  (wr_div_i),
         .o_clk  (clk_o[c]),
         .o_tick (tick_o[c])
      );
   end

endmodule

// File: tb/tb_t01_clkdiv_multi.sv
// Randomised bench for t01_clkdiv_multi against a half-period model.
// DUT A: 4 channels default sizes; DUT B: 3 channels, 4-bit, for range errors.
module tb_t01_clkdiv_multi;
   import t01_clkdiv_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] en;
   logic       sclr;
   logic       wa_en;
   logic [1:0] wa_ch;
   div_t       wa_div;
   logic       wb_en;
   logic [1:0] wb_ch;
   logic [3:0] wb_div;
   logic [3:0] clka, ticka;
   logic       erra;
   logic [2:0] clkb, tickb;
   logic       errb;

   int checks = 0;
   int errors = 0;

   // Channels 0..3 belong to DUT A, 4..6 to DUT B.
   int m_div  [7];
   int m_run  [7];
   int m_clk  [7];
   int m_tick [7];
   int m_erra, m_errb;

   always #5 clk = ~clk;

   t01_clkdiv_multi u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en),
      .sync_clr_i (sclr),
      .wr_en_i    (wa_en),
      .wr_ch_i    (wa_ch),
      .wr_div_i   (wa_div),
      .clk_o      (clka),
      .tick_o     (ticka),
      .wr_err_o   (erra)
   );

   t01_clkdiv_multi #(
      .NUM_CH      (3),
      .CNT_W       (4),
      .DEFAULT_DIV (2)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en[2:0]),
      .sync_clr_i (sclr),
      .wr_en_i    (wb_en),
      .wr_ch_i    (wb_ch),
      .wr_div_i   (wb_div),
      .clk_o      (clkb),
      .tick_o     (tickb),
      .wr_err_o   (errb)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] vec(input int lo, input int n,
                                       input bit tick);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++)
         v[i] = tick ? m_tick[lo+i][0] : m_clk[lo+i][0];
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 7; c++) begin
         m_div[c]  = (c < 4) ? 1250 : 2;
         m_run[c]  = 0;
         m_clk[c]  = 0;
         m_tick[c] = 0;
      end
      m_erra = 0;
      m_errb = 0;
   endtask

   // One rising edge: cycles elapsed in the half period reach div+1 -> toggle.
   task automatic model_step();
      for (int c = 0; c < 7; c++) begin
         bit e = (c < 4) ? en[c] : en[c-4];
         if (sclr) begin
            m_run[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
         end else if (!e) begin
            m_run[c] = 0; m_tick[c] = 0;
         end else begin
            m_run[c]++;
            if (m_run[c] >= m_div[c] + 1) begin
               m_run[c]  = 0;
               m_clk[c]  = 1 - m_clk[c];
               m_tick[c] = 1;
            end else begin
               m_tick[c] = 0;
            end
         end
      end
      if (wa_en) m_div[wa_ch] = int'(wa_div);
      m_erra = 0;
      if (wb_en && wb_ch < 3) m_div[4 + wb_ch] = int'(wb_div);
      m_errb = (wb_en && wb_ch == 3) ? 1 : 0;
   endtask

   task automatic check_all();
      chk("clkA",  clka,  vec(0, 4, 0));
      chk("tickA", ticka, vec(0, 4, 1));
      chk("errA",  erra,  m_erra);
      chk("clkB",  clkb,  vec(4, 3, 0));
      chk("tickB", tickb, vec(4, 3, 1));
      chk("errB",  errb,  m_errb);
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
      wa_en = 1'b0;
      wb_en = 1'b0;
      sclr  = 1'b0;
   endtask

   task automatic first_rise(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (clka[0] == 1'b0 && n < 3000);
      chk(tag, n, 1251);
   endtask

   initial begin
      rst = 1'b1; en = '0; sclr = 1'b0;
      wa_en = 1'b0; wa_ch = '0; wa_div = '0;
      wb_en = 1'b0; wb_ch = '0; wb_div = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;

      en = 4'b0001;
      first_rise("first_rise");
      repeat (2600) step();

      wa_en = 1'b1; wa_ch = 2'd2; wa_div = 11'd3;
      step();
      en = 4'b0101;
      repeat (40) step();

      en = 4'b0111;
      repeat (900) step();
      wa_en = 1'b1; wa_ch = 2'd1; wa_div = 11'd100;
      step();
      repeat (250) step();

      wa_en = 1'b1; wa_ch = 2'd3; wa_div = 11'd0;
      step();
      en = 4'b1111;
      repeat (20) step();

      wa_en = 1'b1; wa_ch = 2'd0; wa_div = 11'd3;
      step();
      repeat (5) step();
      sclr = 1'b1;
      wb_en = 1'b1; wb_ch = 2'd3; wb_div = 4'd9;
      step();
      repeat (30) step();

      wb_en = 1'b1; wb_ch = 2'd1; wb_div = 4'd15;
      sclr = 1'b1;
      step();
      repeat (40) step();

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) en = 4'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            wa_en  = 1'b1;
            wa_ch  = 2'($urandom);
            wa_div = ($urandom_range(0, 9) == 0) ?
                     11'($urandom_range(0, 2047)) :
                     11'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 5) == 0) begin
            wb_en  = 1'b1;
            wb_ch  = 2'($urandom);
            wb_div = 4'($urandom);
         end
         if ($urandom_range(0, 63) == 0) sclr = 1'b1;
         step();
      end

      en = 4'b1111;
      wa_en = 1'b1; wa_ch = 2'd0; wa_div = 11'd2;
      step();
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_clk",  clka, 32'd0);
      chk("arst_tick", ticka, 32'd0);
      chk("arst_clkB", clkb, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      en = 4'b0001;
      first_rise("rise_after_rst");
      repeat (20) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
